// File: rtl/tick_pkg.sv
// tick_pkg: shared tick-interface types and default constants
package tick_pkg;
  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, TIMEOUT} tick_state_e;
  localparam int TICK_DIV_DEFAULT     = 100;
  localparam int TICK_TIMEOUT_DEFAULT = 100000000;
endpackage

// File: rtl/tick_minmax.sv
// tick_minmax: running min/max of strobed periods, restartable by clear
module tick_minmax #(
  parameter int p_width = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_stb,
  input  logic [p_width-1:0] i_period,
  output logic [p_width-1:0] o_min,
  output logic [p_width-1:0] o_max
);
  logic [p_width-1:0] min_q, max_q;
  // fold each new period into the extremes; clear restarts from the empty-set values
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (i_stb) begin
      min_q <= (i_period < min_q) ? i_period : min_q;
      max_q <= (i_period > max_q) ? i_period : max_q;
    end
  end
  assign o_min = min_q;
  assign o_max = max_q;
endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures cycles between ticks, flags timeout; min/max tracking under TICK_PERIOD_MINMAX_EN
module tick_period_meter
  import tick_pkg::*;
#(
  parameter int p_timeout = TICK_TIMEOUT_DEFAULT,
  parameter int p_width   = $clog2(p_timeout + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_clear,
  output logic [p_width-1:0] o_period,
  output logic               o_valid,
  output logic               o_timeout
`ifdef TICK_PERIOD_MINMAX_EN
  ,
  output logic [p_width-1:0] o_min,
  output logic [p_width-1:0] o_max
`endif
);
  localparam logic [p_width-1:0] lp_max = p_width'(p_timeout);
  localparam logic [p_width-1:0] lp_one = p_width'(1);
  tick_state_e        state_q;
  logic [p_width-1:0] cnt_q, period_q;
  logic               valid_q, timeout_q;
  // tick/timeout FSM; the counter saturates at p_timeout so it can never wrap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= WAIT_FIRST;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (i_clear) begin
      state_q   <= WAIT_FIRST;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        WAIT_FIRST: if (i_tick) begin
          state_q <= MEASURE;
          cnt_q   <= lp_one;
        end
        MEASURE: if (i_tick) begin
          period_q <= cnt_q;
          valid_q  <= 1'b1;
          cnt_q    <= lp_one;
        end else if (cnt_q == lp_max) begin
          state_q   <= TIMEOUT;
          timeout_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + lp_one;
        end
        TIMEOUT: if (i_tick) begin
          state_q   <= MEASURE;
          cnt_q     <= lp_one;
          timeout_q <= 1'b0;
        end
        default: state_q <= WAIT_FIRST;
      endcase
    end
  end
  assign o_period  = period_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
`ifdef TICK_PERIOD_MINMAX_EN
  logic meas_tick;
  assign meas_tick = (state_q == MEASURE) && i_tick && !i_clear;
  tick_minmax #(.p_width(p_width)) u_minmax (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_stb   (meas_tick),
    .i_period(cnt_q),
    .o_min   (o_min),
    .o_max   (o_max)
  );
`endif
endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: table vectors, corner sequences and random ticks against a timestamp model
module tb_tick_period_meter;
  localparam int TO = 20;
  localparam int W = $clog2(TO + 1);
  localparam int ALL1 = (1 << W) - 1;
  logic i_clk = 1'b0, i_rst = 1'b1, i_tick = 1'b0, i_clear = 1'b0;
  logic [W-1:0] o_period;
  logic o_valid, o_timeout;
`ifdef TICK_PERIOD_MINMAX_EN
  logic [W-1:0] o_min, o_max;
`endif
  always #5 i_clk = ~i_clk;
  tick_period_meter #(.p_timeout(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_clear(i_clear),
    .o_period(o_period), .o_valid(o_valid), .o_timeout(o_timeout)
`ifdef TICK_PERIOD_MINMAX_EN
    , .o_min(o_min), .o_max(o_max)
`endif
  );
  int errors = 0, checks = 0;
  bit m_ref, m_valid, m_timeout;
  longint m_last, cyc = 0;
  int m_period, m_min = ALL1, m_max = 0;
  typedef struct {bit tick; bit exp_valid; int exp_period;} vec_t;
  vec_t tbl[18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // model: only the time of the last accepted tick matters; the gap decides everything
  task automatic step(input bit t, input bit c, input bit r);
    i_tick = t; i_clear = c; i_rst = r;
    if (r) begin
      m_ref = 0; m_period = 0; m_valid = 0; m_timeout = 0; m_min = ALL1; m_max = 0;
    end else if (c) begin
      m_ref = 0; m_valid = 0; m_timeout = 0; m_min = ALL1; m_max = 0;
    end else if (t) begin
      m_valid = m_ref && (cyc - m_last) <= TO;
      if (m_valid) begin
        m_period = int'(cyc - m_last);
        if (m_period < m_min) m_min = m_period;
        if (m_period > m_max) m_max = m_period;
      end
      m_ref = 1; m_last = cyc; m_timeout = 0;
    end else begin
      m_valid = 0;
      m_timeout = m_ref && (cyc + 1 - m_last) > TO;
    end
    @(posedge i_clk); #1;
    cyc++;
    chk("period", 32'(o_period), 32'(m_period));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("timeout", 32'(o_timeout), 32'(m_timeout));
`ifdef TICK_PERIOD_MINMAX_EN
    chk("min", 32'(o_min), 32'(m_min));
    chk("max", 32'(o_max), 32'(m_max));
`endif
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{(i % 5) == 0, (i % 5) == 0 && i > 0, (i < 5) ? 0 : 5};
    tbl[16] = '{1'b1, 1'b1, 1};
    tbl[17] = '{1'b1, 1'b1, 1};
    step(0, 0, 1);
    chk("reset_period", 32'(o_period), 0);
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_timeout", 32'(o_timeout), 0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].tick, 0, 0);
      chk("tbl_valid", 32'(o_valid), 32'(tbl[i].exp_valid));
      chk("tbl_period", 32'(o_period), 32'(tbl[i].exp_period));
    end
    // gap 20 accepted, gap 21 times out, recovery tick unreported
    step(0, 0, 1); step(1, 0, 0); idle(19); step(1, 0, 0);
    chk("gap20_period", 32'(o_period), 20);
    chk("gap20_valid", 32'(o_valid), 1);
    idle(19);
    chk("pre_timeout", 32'(o_timeout), 0);
    idle(1);
    chk("timeout_set", 32'(o_timeout), 1);
    idle(4); step(1, 0, 0);
    chk("timeout_clr", 32'(o_timeout), 0);
    chk("recover_no_valid", 32'(o_valid), 0);
    idle(4); step(1, 0, 0);
    chk("recover_period", 32'(o_period), 5);
    chk("recover_valid", 32'(o_valid), 1);
    // clear collides with tick
    idle(3); step(1, 0, 0);
    chk("pre_clear_period", 32'(o_period), 4);
    idle(2); step(1, 1, 0);
    chk("clear_no_valid", 32'(o_valid), 0);
    chk("clear_keeps_period", 32'(o_period), 4);
    idle(3); step(1, 0, 0);
    chk("after_clear_first", 32'(o_valid), 0);
    idle(2); step(1, 0, 0);
    chk("after_clear_period", 32'(o_period), 3);
    // reset mid-gap
    idle(5); step(0, 0, 1);
    chk("rst_period", 32'(o_period), 0);
    chk("rst_valid", 32'(o_valid), 0);
    step(0, 0, 0); step(1, 0, 0);
    chk("rst_first_tick", 32'(o_valid), 0);
`ifdef TICK_PERIOD_MINMAX_EN
    step(0, 1, 0); step(1, 0, 0); idle(6); step(1, 0, 0); idle(2); step(1, 0, 0); idle(8); step(1, 0, 0);
    chk("mm_min", 32'(o_min), 3);
    chk("mm_max", 32'(o_max), 9);
    step(0, 1, 0);
    chk("mm_clr_min", 32'(o_min), ALL1);
    chk("mm_clr_max", 32'(o_max), 0);
`endif
    begin
      int k;
      k = 3;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) k = int'($urandom_range(0, 3)) * 9;
        step($urandom_range(0, k) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 399) == 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
